// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port SRAM arbiter: requester ports A/B, SRAM pins and status.
// "slave" is the arbiter's view; "master" is the requester/SRAM side.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              A_Req;
    logic              A_WE;
    logic [ADDR_W-1:0] A_Addr;
    logic [DATA_W-1:0] A_Wdata;
    logic              A_Ack;
    logic [DATA_W-1:0] A_Rdata;

    logic              B_Req;
    logic              B_WE;
    logic [ADDR_W-1:0] B_Addr;
    logic [DATA_W-1:0] B_Wdata;
    logic              B_Ack;
    logic [DATA_W-1:0] B_Rdata;

    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Dout;
    logic [DATA_W-1:0] Mem_Din;
    logic              Mem_Drive;
    logic              Mem_CE;
    logic              Mem_OE;
    logic              Mem_WE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Busy;
    logic              Grant;

    modport slave (
        input  A_Req, A_WE, A_Addr, A_Wdata,
        input  B_Req, B_WE, B_Addr, B_Wdata,
        input  Mem_Din,
        output A_Ack, A_Rdata, B_Ack, B_Rdata,
        output Mem_Addr, Mem_Dout, Mem_Drive, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
        output Busy, Grant
    );

    modport master (
        output A_Req, A_WE, A_Addr, A_Wdata,
        output B_Req, B_WE, B_Addr, B_Wdata,
        output Mem_Din,
        input  A_Ack, A_Rdata, B_Ack, B_Rdata,
        input  Mem_Addr, Mem_Dout, Mem_Drive, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
        input  Busy, Grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for an asynchronous SRAM: fixed 2-cycle read/write
// access followed by a one-cycle ACK. All pin outputs are registered.
module mem_arbiter (
    input  logic          Clk,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        ACK  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              last_q;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              win_b;

    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_drive_q, mem_drive_d;
    logic              busy_q, busy_d;

    // Next state, transaction latch and next-cycle pin values decoded from state_d
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.A_Req || bus.B_Req) begin
                    // On a tie the port that did not own the last transaction wins
                    win_b   = bus.B_Req && (!bus.A_Req || !last_q);
                    grant_d = win_b;
                    we_d    = win_b ? bus.B_WE    : bus.A_WE;
                    addr_d  = win_b ? bus.B_Addr  : bus.A_Addr;
                    wdata_d = win_b ? bus.B_Wdata : bus.A_Wdata;
                    state_d = we_d ? WR1 : RD1;
                end
            end
            RD1:     state_d = RD2;
            RD2:     state_d = ACK;
            WR1:     state_d = WR2;
            WR2:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        mem_ce_d    = (state_d == IDLE);
        mem_oe_d    = !((state_d == RD1) || (state_d == RD2));
        mem_we_d    = !((state_d == WR1) || (state_d == WR2));
        // Data stays driven through the ACK after a write for SRAM hold time
        mem_drive_d = (state_d == WR1) || (state_d == WR2) || ((state_d == ACK) && we_d);
        a_ack_d     = (state_d == ACK) && !grant_d;
        b_ack_d     = (state_d == ACK) && grant_d;
        mem_addr_d  = (state_d == IDLE) ? '0 : addr_d;
    end

    // State, latched transaction and registered pins
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_ce_q    <= 1'b1;
            mem_oe_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_drive_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_ce_q    <= mem_ce_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            mem_drive_q <= mem_drive_d;
            busy_q      <= busy_d;
            if (state_q == ACK) begin
                last_q <= grant_q;
            end
        end
    end

    // Read data is sampled at the end of RD2 and held until that port's next read
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (state_q == RD2) begin
            if (grant_q) begin
                b_rdata_q <= bus.Mem_Din;
            end else begin
                a_rdata_q <= bus.Mem_Din;
            end
        end
    end

    assign bus.A_Ack     = a_ack_q;
    assign bus.B_Ack     = b_ack_q;
    assign bus.A_Rdata   = a_rdata_q;
    assign bus.B_Rdata   = b_rdata_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_Dout  = wdata_q;
    assign bus.Mem_Drive = mem_drive_q;
    assign bus.Mem_CE    = mem_ce_q;
    assign bus.Mem_OE    = mem_oe_q;
    assign bus.Mem_WE    = mem_we_q;
    assign bus.Mem_UB    = 1'b0;
    assign bus.Mem_LB    = 1'b0;
    assign bus.Busy      = busy_q;
    assign bus.Grant     = grant_q;
endmodule
